// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and channel FSM state types for the memory responder.
`default_nettype none

package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

`default_nettype wire

// File: rtl/axi4_burst_addr.sv
// ============================================================================
// Module   : axi4_burst_addr
// Brief    : Combinational next-beat address and burst legality check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_burst_addr
    import axi4_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [7:0]  len_i,
    input  logic [2:0]  size_i,
    input  logic [1:0]  burst_i,
    output logic [31:0] next_addr_o,
    output logic        err_o
);

    logic [31:0] inc_addr;
    logic [31:0] wrap_win;
    logic [31:0] wrap_mask;
    logic        wrap_len_ok;

    assign inc_addr  = addr_i + 32'd4;
    // Wrap window is (len+1) beats of 4 bytes; only meaningful for legal lengths.
    assign wrap_win  = ({24'd0, len_i} + 32'd1) << 2;
    assign wrap_mask = wrap_win - 32'd1;

    assign wrap_len_ok = (len_i == 8'd1) || (len_i == 8'd3) ||
                         (len_i == 8'd7) || (len_i == 8'd15);

    always_comb begin
        next_addr_o = addr_i;
        unique case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_INCR:  next_addr_o = inc_addr;
            BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (inc_addr & wrap_mask);
            default:     next_addr_o = addr_i;
        endcase
    end

    assign err_o = (size_i != SIZE_4B) ||
                   (burst_i == 2'b11) ||
                   ((burst_i == BURST_WRAP) && !wrap_len_ok);

endmodule

`default_nettype wire

// File: rtl/axi4_slave_mem.sv
// ============================================================================
// Module   : axi4_slave_mem
// Brief    : AXI4 responder over a word RAM; independent single-outstanding
//            write and read FSMs. Define AXI_SLAVE_DECODE_ERR_EN to flag word
//            indices beyond MEM_WORDS as SLVERR instead of wrapping them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_slave_mem
    import axi4_pkg::*;
#(
    parameter int ID_WIDTH  = 4,
    parameter int MEM_WORDS = 256
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [ID_WIDTH-1:0] S_AXI_AWID,
    input  logic [31:0]         S_AXI_AWADDR,
    input  logic [7:0]          S_AXI_AWLEN,
    input  logic [2:0]          S_AXI_AWSIZE,
    input  logic [1:0]          S_AXI_AWBURST,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [31:0]         S_AXI_WDATA,
    input  logic [3:0]          S_AXI_WSTRB,
    input  logic                S_AXI_WLAST,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [ID_WIDTH-1:0] S_AXI_BID,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [ID_WIDTH-1:0] S_AXI_ARID,
    input  logic [31:0]         S_AXI_ARADDR,
    input  logic [7:0]          S_AXI_ARLEN,
    input  logic [2:0]          S_AXI_ARSIZE,
    input  logic [1:0]          S_AXI_ARBURST,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [ID_WIDTH-1:0] S_AXI_RID,
    output logic [31:0]         S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RLAST,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [31:0] mem_q [MEM_WORDS];

    w_state_e            wr_state_q, wr_state_d;
    logic                aw_ready_q, aw_ready_d;
    logic                w_ready_q, w_ready_d;
    logic                b_valid_q, b_valid_d;
    logic [1:0]          b_resp_q, b_resp_d;
    logic [ID_WIDTH-1:0] wr_id_q, wr_id_d;
    logic [31:0]         wr_addr_q, wr_addr_d;
    logic [7:0]          wr_len_q, wr_len_d;
    logic [7:0]          wr_cnt_q, wr_cnt_d;
    logic [1:0]          wr_burst_q, wr_burst_d;
    logic                wr_illegal_q, wr_illegal_d;
    logic                wr_slverr_q, wr_slverr_d;
    logic                wr_last_beat, wr_oor, mem_we;
    logic [31:0]         wr_ba_addr, wr_next_addr;
    logic [7:0]          wr_ba_len;
    logic [2:0]          wr_ba_size;
    logic [1:0]          wr_ba_burst;
    logic                wr_ba_err;

    r_state_e            rd_state_q, rd_state_d;
    logic                ar_ready_q, ar_ready_d;
    logic                r_valid_q, r_valid_d;
    logic                r_last_q, r_last_d;
    logic [1:0]          r_resp_q, r_resp_d;
    logic [31:0]         r_data_q, r_data_d;
    logic [ID_WIDTH-1:0] rd_id_q, rd_id_d;
    logic [31:0]         rd_addr_q, rd_addr_d;
    logic [7:0]          rd_len_q, rd_len_d;
    logic [7:0]          rd_cnt_q, rd_cnt_d;
    logic [1:0]          rd_burst_q, rd_burst_d;
    logic                rd_illegal_q, rd_illegal_d;
    logic                rd_oor;
    logic [31:0]         rd_ba_addr, rd_next_addr, rd_beat_addr, rd_word;
    logic [7:0]          rd_ba_len;
    logic [2:0]          rd_ba_size;
    logic [1:0]          rd_ba_burst;
    logic                rd_ba_err;

    // In IDLE the address units judge the incoming request; afterwards they
    // step the latched burst address.
    always_comb begin
        wr_ba_addr  = wr_addr_q;
        wr_ba_len   = wr_len_q;
        wr_ba_size  = SIZE_4B;
        wr_ba_burst = wr_burst_q;
        if (wr_state_q == W_IDLE) begin
            wr_ba_addr  = S_AXI_AWADDR;
            wr_ba_len   = S_AXI_AWLEN;
            wr_ba_size  = S_AXI_AWSIZE;
            wr_ba_burst = S_AXI_AWBURST;
        end
    end

    always_comb begin
        rd_ba_addr  = rd_addr_q;
        rd_ba_len   = rd_len_q;
        rd_ba_size  = SIZE_4B;
        rd_ba_burst = rd_burst_q;
        if (rd_state_q == R_IDLE) begin
            rd_ba_addr  = S_AXI_ARADDR;
            rd_ba_len   = S_AXI_ARLEN;
            rd_ba_size  = S_AXI_ARSIZE;
            rd_ba_burst = S_AXI_ARBURST;
        end
    end

    axi4_burst_addr u_wr_addr (
        .addr_i      (wr_ba_addr),
        .len_i       (wr_ba_len),
        .size_i      (wr_ba_size),
        .burst_i     (wr_ba_burst),
        .next_addr_o (wr_next_addr),
        .err_o       (wr_ba_err)
    );

    axi4_burst_addr u_rd_addr (
        .addr_i      (rd_ba_addr),
        .len_i       (rd_ba_len),
        .size_i      (rd_ba_size),
        .burst_i     (rd_ba_burst),
        .next_addr_o (rd_next_addr),
        .err_o       (rd_ba_err)
    );

    // Address of the read beat that will be loaded into RDATA this cycle.
    assign rd_beat_addr = (rd_state_q == R_IDLE) ? S_AXI_ARADDR : rd_next_addr;
    assign rd_word      = mem_q[rd_beat_addr[IDX_W+1:2]];

`ifdef AXI_SLAVE_DECODE_ERR_EN
    assign wr_oor = |wr_addr_q[31:IDX_W+2];
    assign rd_oor = |rd_beat_addr[31:IDX_W+2];
`else
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
`endif

    always_comb begin
        wr_state_d   = wr_state_q;
        aw_ready_d   = aw_ready_q;
        w_ready_d    = w_ready_q;
        b_valid_d    = b_valid_q;
        b_resp_d     = b_resp_q;
        wr_id_d      = wr_id_q;
        wr_addr_d    = wr_addr_q;
        wr_len_d     = wr_len_q;
        wr_cnt_d     = wr_cnt_q;
        wr_burst_d   = wr_burst_q;
        wr_illegal_d = wr_illegal_q;
        wr_slverr_d  = wr_slverr_q;
        wr_last_beat = (wr_cnt_q == wr_len_q);
        mem_we       = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                aw_ready_d = 1'b1;
                if (aw_ready_q && S_AXI_AWVALID) begin
                    wr_id_d      = S_AXI_AWID;
                    wr_addr_d    = S_AXI_AWADDR;
                    wr_len_d     = S_AXI_AWLEN;
                    wr_burst_d   = S_AXI_AWBURST;
                    wr_cnt_d     = 8'd0;
                    wr_illegal_d = wr_ba_err;
                    wr_slverr_d  = wr_ba_err;
                    aw_ready_d   = 1'b0;
                    w_ready_d    = 1'b1;
                    wr_state_d   = W_DATA;
                end
            end
            W_DATA: begin
                if (w_ready_q && S_AXI_WVALID) begin
                    mem_we      = !wr_illegal_q && !wr_oor && !ARESET;
                    // A misplaced WLAST is reported but the burst length stays authoritative.
                    wr_slverr_d = wr_slverr_q || (S_AXI_WLAST != wr_last_beat) || wr_oor;
                    wr_addr_d   = wr_next_addr;
                    wr_cnt_d    = wr_cnt_q + 8'd1;
                    if (wr_last_beat) begin
                        w_ready_d  = 1'b0;
                        b_valid_d  = 1'b1;
                        b_resp_d   = wr_slverr_d ? RESP_SLVERR : RESP_OKAY;
                        wr_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    b_valid_d  = 1'b0;
                    b_resp_d   = RESP_OKAY;
                    aw_ready_d = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d   = rd_state_q;
        ar_ready_d   = ar_ready_q;
        r_valid_d    = r_valid_q;
        r_last_d     = r_last_q;
        r_resp_d     = r_resp_q;
        r_data_d     = r_data_q;
        rd_id_d      = rd_id_q;
        rd_addr_d    = rd_addr_q;
        rd_len_d     = rd_len_q;
        rd_cnt_d     = rd_cnt_q;
        rd_burst_d   = rd_burst_q;
        rd_illegal_d = rd_illegal_q;
        unique case (rd_state_q)
            R_IDLE: begin
                ar_ready_d = 1'b1;
                if (ar_ready_q && S_AXI_ARVALID) begin
                    rd_id_d      = S_AXI_ARID;
                    rd_addr_d    = S_AXI_ARADDR;
                    rd_len_d     = S_AXI_ARLEN;
                    rd_burst_d   = S_AXI_ARBURST;
                    rd_cnt_d     = 8'd0;
                    rd_illegal_d = rd_ba_err;
                    r_data_d     = (rd_ba_err || rd_oor) ? 32'd0 : rd_word;
                    r_resp_d     = (rd_ba_err || rd_oor) ? RESP_SLVERR : RESP_OKAY;
                    r_last_d     = (S_AXI_ARLEN == 8'd0);
                    r_valid_d    = 1'b1;
                    ar_ready_d   = 1'b0;
                    rd_state_d   = R_DATA;
                end
            end
            R_DATA: begin
                if (r_valid_q && S_AXI_RREADY) begin
                    if (r_last_q) begin
                        r_valid_d  = 1'b0;
                        r_last_d   = 1'b0;
                        r_data_d   = 32'd0;
                        r_resp_d   = RESP_OKAY;
                        ar_ready_d = 1'b1;
                        rd_state_d = R_IDLE;
                    end else begin
                        // Next beat is fetched on the accepting edge for back-to-back beats.
                        rd_addr_d = rd_next_addr;
                        rd_cnt_d  = rd_cnt_q + 8'd1;
                        r_data_d  = (rd_illegal_q || rd_oor) ? 32'd0 : rd_word;
                        r_resp_d  = (rd_illegal_q || rd_oor) ? RESP_SLVERR : RESP_OKAY;
                        r_last_d  = ((rd_cnt_q + 8'd1) == rd_len_q);
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem_q[wr_addr_q[IDX_W+1:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q   <= W_IDLE;
            aw_ready_q   <= 1'b0;
            w_ready_q    <= 1'b0;
            b_valid_q    <= 1'b0;
            b_resp_q     <= RESP_OKAY;
            wr_id_q      <= '0;
            wr_addr_q    <= 32'd0;
            wr_len_q     <= 8'd0;
            wr_cnt_q     <= 8'd0;
            wr_burst_q   <= BURST_FIXED;
            wr_illegal_q <= 1'b0;
            wr_slverr_q  <= 1'b0;
            rd_state_q   <= R_IDLE;
            ar_ready_q   <= 1'b0;
            r_valid_q    <= 1'b0;
            r_last_q     <= 1'b0;
            r_resp_q     <= RESP_OKAY;
            r_data_q     <= 32'd0;
            rd_id_q      <= '0;
            rd_addr_q    <= 32'd0;
            rd_len_q     <= 8'd0;
            rd_cnt_q     <= 8'd0;
            rd_burst_q   <= BURST_FIXED;
            rd_illegal_q <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            aw_ready_q   <= aw_ready_d;
            w_ready_q    <= w_ready_d;
            b_valid_q    <= b_valid_d;
            b_resp_q     <= b_resp_d;
            wr_id_q      <= wr_id_d;
            wr_addr_q    <= wr_addr_d;
            wr_len_q     <= wr_len_d;
            wr_cnt_q     <= wr_cnt_d;
            wr_burst_q   <= wr_burst_d;
            wr_illegal_q <= wr_illegal_d;
            wr_slverr_q  <= wr_slverr_d;
            rd_state_q   <= rd_state_d;
            ar_ready_q   <= ar_ready_d;
            r_valid_q    <= r_valid_d;
            r_last_q     <= r_last_d;
            r_resp_q     <= r_resp_d;
            r_data_q     <= r_data_d;
            rd_id_q      <= rd_id_d;
            rd_addr_q    <= rd_addr_d;
            rd_len_q     <= rd_len_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_burst_q   <= rd_burst_d;
            rd_illegal_q <= rd_illegal_d;
        end
    end

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = w_ready_q;
    assign S_AXI_BID     = wr_id_q;
    assign S_AXI_BRESP   = b_resp_q;
    assign S_AXI_BVALID  = b_valid_q;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RID     = rd_id_q;
    assign S_AXI_RDATA   = r_data_q;
    assign S_AXI_RRESP   = r_resp_q;
    assign S_AXI_RLAST   = r_last_q;
    assign S_AXI_RVALID  = r_valid_q;

endmodule

`default_nettype wire

// File: doc/axi4_slave_mem.md
Name: axi4_slave_mem

Overview:
AXI4-full responder backed by an internal word-addressed RAM. It is the target end of the AXI4 master.
Independent write and read channel FSMs; one outstanding transaction per direction.
Supports FIXED, INCR and WRAP bursts of 32-bit beats.
AxPROT, AxCACHE, AxLOCK, AxQOS and AxREGION are not ported: the master's outputs stay unconnected.

Parameters:
ID_WIDTH, 4, width of AWID/BID/ARID/RID
MEM_WORDS, 256, RAM depth in 32-bit words (power of 2)

Ports:
ACLK  in  1  clock, all logic on posedge
ARESET  in  1  synchronous, active-high reset
S_AXI_AWID  in  ID_WIDTH  write ID
S_AXI_AWADDR  in  32  write byte address
S_AXI_AWLEN  in  8  beats-1
S_AXI_AWSIZE  in  3  beat size
S_AXI_AWBURST  in  2  burst type
S_AXI_AWVALID  in  1  AW valid
S_AXI_AWREADY  out  1  AW ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WLAST  in  1  last write beat
S_AXI_WVALID  in  1  W valid
S_AXI_WREADY  out  1  W ready
S_AXI_BID  out  ID_WIDTH  response ID
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  B valid
S_AXI_BREADY  in  1  B ready
S_AXI_ARID  in  ID_WIDTH  read ID
S_AXI_ARADDR  in  32  read byte address
S_AXI_ARLEN  in  8  beats-1
S_AXI_ARSIZE  in  3  beat size
S_AXI_ARBURST  in  2  burst type
S_AXI_ARVALID  in  1  AR valid
S_AXI_ARREADY  out  1  AR ready
S_AXI_RID  out  ID_WIDTH  read ID
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RLAST  out  1  last read beat
S_AXI_RVALID  out  1  R valid
S_AXI_RREADY  in  1  R ready

Behaviour:
- Reset (ARESET=1 at a posedge): all outputs are 0, both FSMs go to IDLE, RAM contents are kept. A reset mid-burst aborts the burst; no B or R is issued for it.
- Write FSM W_IDLE/W_DATA/W_RESP:
  - W_IDLE: AWREADY=1, WREADY=0. On AW handshake, latch ID, addr, len, burst and the error flag, and clear the beat count. Next cycle: AWREADY=0, WREADY=1, state W_DATA.
  - W_DATA: each W handshake writes the strobed bytes to mem[word], where word = addr[31:2] mod MEM_WORDS. Address then advances.
  - The beat where count==len ends data: WREADY=0, BVALID=1, state W_RESP.
  - If WLAST disagrees with (count==len) on any beat, set SLVERR. Exactly len+1 beats are still accepted.
  - W_RESP: hold BVALID, BID and BRESP stable until BREADY. Then BVALID=0, state W_IDLE.
- Read FSM R_IDLE/R_DATA:
  - R_IDLE: ARREADY=1. On AR handshake, register RDATA<=mem[word], RID, RLAST<=(len==0). Next cycle: RVALID=1, ARREADY=0.
  - R_DATA: on an R handshake that is not last, load the next beat's RDATA and RLAST in the same edge. RVALID stays 1, so beats are back-to-back.
  - On the last handshake: RVALID=0, RLAST=0, state R_IDLE.
  - RVALID, RDATA, RRESP and RLAST are held stable while RREADY=0.
- Address generation per beat:
  - FIXED: unchanged.
  - INCR: +4.
  - WRAP: +4 within a (len+1)*4-byte aligned window; addr = base | ((addr+4) & (size-1)).
- Error conditions give SLVERR on every R beat or on B:
  - AxSIZE != 3'b010.
  - AxBURST == 2'b11.
  - WRAP with len not in {1,3,7,15}.
  - Errored writes do not modify RAM. Errored reads return RDATA=0.
- A read and a write to the same word in the same cycle: the read returns the old data.
- 4 KB boundary crossing is not checked.

Optional Feature:
AXI_SLAVE_DECODE_ERR_EN.
- Defined: a word index >= MEM_WORDS (AxADDR[31:2]) is out of range. That beat's write is suppressed, its RDATA is 0, and the response is SLVERR (DECERR is not used).
- Undefined: the index is taken mod MEM_WORDS and the response is OKAY.

Decomposition:
- Package axi4_pkg holds:
  - BURST_FIXED/INCR/WRAP.
  - RESP_OKAY/SLVERR.
  - SIZE_4B.
  - Write and read FSM state encodings.
- Sub-module axi4_burst_addr: combinational next-address and legality check (inputs addr, len, size, burst; outputs next_addr, err). Instantiated once per channel.

Test Plan:
- Single write then read: AW addr 0x4, WDATA 0x12345678, WSTRB 4'hF, len 0 -> BRESP OKAY, BID matches AWID; a read of 0x4 returns 0x12345678 with RLAST=1 and RRESP OKAY.
- INCR write, len 3 at 0x10, data 0xA0..0xA3 -> one B. INCR read, len 3 -> four back-to-back R beats 0xA0..0xA3 under RREADY=1, with RLAST only on beat 4.
- WRAP read, len 3 at 0x18 -> words 0x18, 0x1C, 0x10, 0x14. WRAP with len 2 -> SLVERR on all 3 beats.
- Partial strobe: write 0xFFFFFFFF to 0x20, then 0x00000000 with WSTRB 4'b0101 -> read returns 0xFF00FF00.
- Backpressure: hold BREADY=0 for 5 cycles and toggle RREADY -> BVALID and RVALID/RDATA stay stable; no beat is lost or duplicated.
- Reset mid-burst: assert ARESET during beat 2 of a len 7 read -> all outputs are 0 next cycle; a new AR is accepted after release.
